// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the datapath ALU: accept, execute for one
// cycle, then hold a writeback / branch-resolution response until consumed.
module alu_issue_ctrl #(
  parameter int unsigned bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [bit_size-1:0] rs_data,
  input  logic [bit_size-1:0] rt_data,
  input  logic [31:0]         pc,
  output logic [3:0]          ALUOp,
  output logic [bit_size-1:0] src1,
  output logic [bit_size-1:0] src2,
  output logic [4:0]          shamt,
  input  logic [bit_size-1:0] ALU_result,
  input  logic                Zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                wb_en,
  output logic [4:0]          wb_addr,
  output logic [bit_size-1:0] wb_data,
  output logic                br_taken,
  output logic [31:0]         br_target,
  output logic                illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;

  logic [3:0]          d_op;
  logic [bit_size-1:0] d_src1, d_src2;
  logic [4:0]          d_shamt, d_dest;
  logic                d_wr, d_beq, d_bne, d_ill;
  logic [31:0]         d_tgt;
  logic [bit_size-1:0] imm_sext, imm_zext;

  logic                wb_en_q, beq_q, bne_q, ill_q;
  logic [4:0]          wb_addr_q;
  logic [31:0]         tgt_q;
  logic                exec_taken;

  // The rs register number is resolved upstream; only its data arrives here.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  assign in_ready = (state == IDLE);
  assign imm_sext = {{(bit_size-16){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(bit_size-16){1'b0}}, instr[15:0]};
  assign d_tgt    = pc + 32'd4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign exec_taken = (beq_q & Zero) | (bne_q & ~Zero);

  always_comb begin
    d_op    = 4'b0000;
    d_src1  = '0;
    d_src2  = '0;
    d_shamt = '0;
    d_dest  = '0;
    d_wr    = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_ill   = 1'b0;
    case (instr[31:26])
      6'h00: begin
        d_src1 = rs_data;
        d_src2 = rt_data;
        d_dest = instr[15:11];
        d_wr   = 1'b1;
        case (instr[5:0])
          6'h20: d_op = 4'b0001;
          6'h22: d_op = 4'b0010;
          6'h24: d_op = 4'b0011;
          6'h25: d_op = 4'b0100;
          6'h26: d_op = 4'b0101;
          6'h27: d_op = 4'b0110;
          6'h2A: d_op = 4'b0111;
          6'h00, 6'h02: begin
            d_op    = (instr[1]) ? 4'b1001 : 4'b1000;
            d_src1  = '0;
            d_shamt = instr[10:6];
          end
          default: begin
            d_src1 = '0;
            d_src2 = '0;
            d_dest = '0;
            d_wr   = 1'b0;
            d_ill  = 1'b1;
          end
        endcase
      end
      6'h08: begin d_op = 4'b0001; d_src1 = rs_data; d_src2 = imm_sext; d_dest = instr[20:16]; d_wr = 1'b1; end
      6'h0A: begin d_op = 4'b0111; d_src1 = rs_data; d_src2 = imm_sext; d_dest = instr[20:16]; d_wr = 1'b1; end
      6'h0C: begin d_op = 4'b0011; d_src1 = rs_data; d_src2 = imm_zext; d_dest = instr[20:16]; d_wr = 1'b1; end
      6'h0D: begin d_op = 4'b0100; d_src1 = rs_data; d_src2 = imm_zext; d_dest = instr[20:16]; d_wr = 1'b1; end
      6'h04: begin d_op = 4'b0010; d_src1 = rs_data; d_src2 = rt_data; d_beq = 1'b1; end
      6'h05: begin d_op = 4'b0010; d_src1 = rs_data; d_src2 = rt_data; d_bne = 1'b1; end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ALUOp     <= '0;
      src1      <= '0;
      src2      <= '0;
      shamt     <= '0;
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
      tgt_q     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ALUOp     <= d_op;
          src1      <= d_src1;
          src2      <= d_src2;
          shamt     <= d_shamt;
          wb_en_q   <= d_wr & (d_dest != 5'd0);
          wb_addr_q <= d_dest;
          beq_q     <= d_beq;
          bne_q     <= d_bne;
          ill_q     <= d_ill;
          tgt_q     <= d_tgt;
          state     <= EXEC;
        end
        EXEC: begin
          ALUOp     <= '0;
          src1      <= '0;
          src2      <= '0;
          shamt     <= '0;
          wb_data   <= ALU_result;
          wb_en     <= wb_en_q;
          wb_addr   <= wb_addr_q;
          illegal   <= ill_q;
          br_taken  <= exec_taken;
          br_target <= exec_taken ? tgt_q : '0;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          wb_en     <= 1'b0;
          wb_addr   <= '0;
          wb_data   <= '0;
          br_taken  <= 1'b0;
          br_target <= '0;
          illegal   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
